// File: rtl/cpu_pkg.sv
// Shared fetch-path types and sizes: fetch FSM states and the halfword/word
// geometry used to walk a mixed 16/32-bit instruction stream.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int          HALF_W     = 16;
  localparam int          WORD_W     = 32;
  localparam logic [31:0] HALF_BYTES = 32'd2;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // A halfword whose two low bits are 11 opens a 32-bit instruction.
  function automatic logic is_full_width(input logic [HALF_W-1:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Halfword alignment for the fetcher: picks the instruction out of the spill
// register and/or the returned word, and computes the follow-on spill and pc.
module fetch_aligner
  import cpu_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [HALF_W-1:0] spill,
  input  logic              spill_valid,
  input  logic [WORD_W-1:0] word,
  output logic              spill_only,
  output logic [31:0]       spill_instr,
  output logic [31:0]       spill_pc_next,
  output logic [31:0]       fetch_addr,
  output logic              resp_out,
  output logic [31:0]       resp_instr,
  output logic [HALF_W-1:0] resp_spill,
  output logic              resp_spill_valid,
  output logic [31:0]       resp_pc_next
);

  logic        straddle;
  logic [31:0] word_base;

  always_comb begin
    word_base     = {pc[31:2], 2'b00};
    straddle      = pc[1] && spill_valid && is_full_width(spill);
    spill_only    = pc[1] && spill_valid && !is_full_width(spill);
    spill_instr   = {16'h0000, spill};
    spill_pc_next = pc + HALF_BYTES;
    // A straddling instruction already has its low half in spill; only the
    // following word is needed.
    fetch_addr    = straddle ? (word_base + WORD_BYTES) : word_base;

    resp_out         = 1'b1;
    resp_instr       = word;
    resp_spill       = word[31:16];
    resp_spill_valid = 1'b1;
    resp_pc_next     = pc + WORD_BYTES;

    if (!pc[1]) begin
      if (is_full_width(word[15:0])) begin
        resp_spill_valid = 1'b0;
      end else begin
        resp_instr   = {16'h0000, word[15:0]};
        resp_pc_next = pc + HALF_BYTES;
      end
    end else if (spill_valid) begin
      resp_instr = {word[15:0], spill};
    end else begin
      // Landed on an upper halfword after a redirect: just prime the spill.
      resp_out     = 1'b0;
      resp_pc_next = pc;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: one outstanding word read at a time, a halfword spill
// register for compressed/straddling instructions, and a registered output.
module fetcher
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        fetcher_valid,
  input  logic        decoder_ready,
  output logic [31:0] instr,
  output logic [31:0] fetcher_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t      state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [HALF_W-1:0] spill_reg, spill_next;
  logic              spill_valid_reg, spill_valid_next;
  logic              out_valid_reg, out_valid_next;
  logic [31:0]       instr_reg, instr_next;
  logic [31:0]       out_pc_reg, out_pc_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;

  logic              can_start;
  logic              spill_only;
  logic [31:0]       spill_instr;
  logic [31:0]       spill_pc_next;
  logic [31:0]       fetch_addr;
  logic              resp_out;
  logic [31:0]       resp_instr;
  logic [HALF_W-1:0] resp_spill;
  logic              resp_spill_valid;
  logic [31:0]       resp_pc_next;

  fetch_aligner u_aligner (
    .pc               (pc_reg),
    .spill            (spill_reg),
    .spill_valid      (spill_valid_reg),
    .word             (mem_rdata),
    .spill_only       (spill_only),
    .spill_instr      (spill_instr),
    .spill_pc_next    (spill_pc_next),
    .fetch_addr       (fetch_addr),
    .resp_out         (resp_out),
    .resp_instr       (resp_instr),
    .resp_spill       (resp_spill),
    .resp_spill_valid (resp_spill_valid),
    .resp_pc_next     (resp_pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC & ~32'd1;
      spill_reg       <= '0;
      spill_valid_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      instr_reg       <= '0;
      out_pc_reg      <= '0;
      mem_addr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      spill_reg       <= spill_next;
      spill_valid_reg <= spill_valid_next;
      out_valid_reg   <= out_valid_next;
      instr_reg       <= instr_next;
      out_pc_reg      <= out_pc_next;
      mem_addr_reg    <= mem_addr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    spill_next       = spill_reg;
    spill_valid_next = spill_valid_reg;
    out_valid_next   = out_valid_reg && !decoder_ready;
    instr_next       = instr_reg;
    out_pc_next      = out_pc_reg;
    mem_addr_next    = mem_addr_reg;
    can_start        = !out_valid_reg || decoder_ready;

    if (redirect_valid) begin
      pc_next          = redirect_pc & ~32'd1;
      spill_valid_next = 1'b0;
      out_valid_next   = 1'b0;
      // A request completing this very cycle has nothing left to drain.
      if (state_reg != IDLE) begin
        state_next = mem_ready ? IDLE : FLUSH;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (can_start) begin
            if (spill_only) begin
              out_valid_next   = 1'b1;
              instr_next       = spill_instr;
              out_pc_next      = pc_reg;
              pc_next          = spill_pc_next;
              spill_valid_next = 1'b0;
            end else begin
              state_next    = FETCH;
              mem_addr_next = fetch_addr;
            end
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state_next       = IDLE;
            pc_next          = resp_pc_next;
            spill_next       = resp_spill;
            spill_valid_next = resp_spill_valid;
            if (resp_out) begin
              out_valid_next = 1'b1;
              instr_next     = resp_instr;
              out_pc_next    = pc_reg;
            end
          end
        end
        FLUSH: begin
          if (mem_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mem_valid     = (state_reg == FETCH) || (state_reg == FLUSH);
  assign mem_addr      = mem_addr_reg;
  assign fetcher_valid = out_valid_reg;
  assign instr         = instr_reg;
  assign fetcher_pc    = out_pc_reg;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: a halfword-array memory with variable
// latency and a stream model that walks that memory from the current pc.
module tb_fetcher;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        fetcher_valid;
  logic        decoder_ready;
  logic [31:0] instr;
  logic [31:0] fetcher_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;

  logic [15:0] hmem [0:2047];
  logic [31:0] model_pc;
  logic [31:0] acc_pc [$];
  logic [31:0] acc_ins [$];
  logic [31:0] fetch_log [$];

  fetcher #(.RESET_PC(RESET_PC_TB)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .fetcher_valid  (fetcher_valid),
    .decoder_ready  (decoder_ready),
    .instr          (instr),
    .fetcher_pc     (fetcher_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    return hmem[a[11:1]];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {hmem[{a[11:2], 1'b1}], hmem[{a[11:2], 1'b0}]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    hmem[{a[11:2], 1'b0}] = w[15:0];
    hmem[{a[11:2], 1'b1}] = w[31:16];
  endtask

  task automatic load_default();
    for (int i = 0; i < 2048; i += 2) begin
      hmem[i]     = 16'h0013;
      hmem[i + 1] = 16'h0000;
    end
  endtask

  // Next instruction of the stream at model_pc, decoded from the length rule.
  task automatic model_next(output logic [31:0] e_pc, output logic [31:0] e_ins);
    logic [15:0] lo;
    e_pc = model_pc;
    lo   = hw_at(model_pc);
    if (lo[1:0] == 2'b11) begin
      e_ins    = {hw_at(model_pc + 32'd2), lo};
      model_pc = model_pc + 32'd4;
    end else begin
      e_ins    = {16'h0000, lo};
      model_pc = model_pc + 32'd2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    chk("rst_fetcher_valid", 32'(fetcher_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_fetcher_pc", fetcher_pc, 32'd0);
  endtask

  task automatic release_reset();
    tick();
    tick();
    acc_pc.delete();
    acc_ins.delete();
    fetch_log.delete();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 300 && acc_pc.size() < n; i++) tick();
    chk("wait_acc", 32'(acc_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_fv();
    for (int i = 0; i < 300 && !fetcher_valid; i++) tick();
    chk("wait_fetcher_valid", 32'(fetcher_valid), 32'd1);
  endtask

  // Memory responder: holds ready off for mem_lat cycles, checks request stability.
  initial begin
    bit          pending;
    int          wait_cnt;
    logic [31:0] req_addr;
    pending   = 1'b0;
    wait_cnt  = 0;
    req_addr  = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          chk("mem_valid_hold", 32'(mem_valid), 32'd1);
          chk("mem_addr_hold", mem_addr, req_addr);
        end else if (mem_valid) begin
          pending  = 1'b1;
          req_addr = mem_addr;
          wait_cnt = 0;
        end
        if (pending && mem_valid) begin
          if (wait_cnt >= mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = word_at(mem_addr);
            fetch_log.push_back(mem_addr);
            pending = 1'b0;
          end else begin
            wait_cnt++;
          end
        end else begin
          pending = 1'b0;
        end
      end
    end
  end

  // Compare process: every transfer against the stream model, plus hold stability.
  initial begin
    bit          hold_prev;
    logic [31:0] hp_instr, hp_pc, e_pc, e_ins;
    hold_prev = 1'b0;
    hp_instr  = 32'd0;
    hp_pc     = 32'd0;
    model_pc  = RESET_PC_TB & ~32'd1;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 1'b0;
        model_pc  = RESET_PC_TB & ~32'd1;
      end else begin
        chk("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        if (hold_prev) begin
          chk("hold_valid", 32'(fetcher_valid), 32'd1);
          chk("hold_instr", instr, hp_instr);
          chk("hold_pc", fetcher_pc, hp_pc);
        end
        if (redirect_valid) begin
          model_pc  = redirect_pc & ~32'd1;
          hold_prev = 1'b0;
        end else begin
          if (fetcher_valid && decoder_ready) begin
            model_next(e_pc, e_ins);
            acc_pc.push_back(fetcher_pc);
            acc_ins.push_back(instr);
            $display("xfer pc=%h instr=%h (model pc=%h instr=%h)", fetcher_pc, instr, e_pc, e_ins);
            chk("xfer_pc", fetcher_pc, e_pc);
            chk("xfer_instr", instr, e_ins);
          end
          hold_prev = fetcher_valid && !decoder_ready;
          hp_instr  = instr;
          hp_pc     = fetcher_pc;
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    decoder_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    load_default();
    tick();

    // Aligned 32-bit instruction, one-cycle memory.
    assert_reset();
    load_default();
    set_word(32'h0, 32'h0050_0093);
    mem_lat = 0;
    decoder_ready = 1'b1;
    release_reset();
    wait_acc(2);
    chk("a_pc0", acc_pc[0], 32'h0);
    chk("a_ins0", acc_ins[0], 32'h0050_0093);
    chk("a_fetch0", fetch_log[0], 32'h0);
    chk("a_fetch1", fetch_log[1], 32'h4);

    // Two compressed instructions from one word, no refetch of address 0.
    assert_reset();
    load_default();
    set_word(32'h0, 32'h4505_4501);
    mem_lat = 1;
    release_reset();
    wait_acc(3);
    chk("b_ins0", acc_ins[0], 32'h0000_4501);
    chk("b_pc1", acc_pc[1], 32'h2);
    chk("b_ins1", acc_ins[1], 32'h0000_4505);
    chk("b_fetch1", fetch_log[1], 32'h4);

    // Compressed then a 32-bit instruction straddling the word boundary.
    assert_reset();
    load_default();
    set_word(32'h0, 32'h0093_4501);
    set_word(32'h4, 32'h1234_0050);
    release_reset();
    wait_acc(3);
    chk("c_ins0", acc_ins[0], 32'h0000_4501);
    chk("c_pc1", acc_pc[1], 32'h2);
    chk("c_ins1", acc_ins[1], 32'h0050_0093);
    chk("c_pc2", acc_pc[2], 32'h6);
    chk("c_ins2", acc_ins[2], 32'h0000_1234);

    // Redirect while a fetch at 0x40 is outstanding.
    assert_reset();
    load_default();
    set_word(32'h40, 32'h4401_4401);
    set_word(32'h100, 32'h4585_0001);
    mem_lat = 0;
    decoder_ready = 1'b0;
    release_reset();
    wait_fv();
    mem_lat = 4;
    redirect(32'h40);
    for (int i = 0; i < 50 && !(mem_valid && mem_addr == 32'h40); i++) tick();
    chk("d_fetch40_seen", 32'(mem_valid && mem_addr == 32'h40), 32'd1);
    tick();
    redirect(32'h0000_0102);
    decoder_ready = 1'b1;
    wait_acc(2);
    chk("d_pc0", acc_pc[0], 32'h102);
    chk("d_ins0", acc_ins[0], 32'h0000_4585);
    chk("d_fetch1", fetch_log[1], 32'h40);
    chk("d_fetch2", fetch_log[2], 32'h100);
    mem_lat = 1;

    // Decoder stall with output full and spill consumed.
    assert_reset();
    load_default();
    set_word(32'h0, 32'h4505_4501);
    mem_lat = 0;
    decoder_ready = 1'b0;
    release_reset();
    wait_fv();
    decoder_ready = 1'b1;
    tick();
    decoder_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("e_stall_valid", 32'(fetcher_valid), 32'd1);
      chk("e_stall_instr", instr, 32'h0000_4505);
      chk("e_stall_pc", fetcher_pc, 32'h2);
      chk("e_stall_memvalid", 32'(mem_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("e_fetch_count", 32'(fetch_log.size()), 32'd1);
    decoder_ready = 1'b1;
    wait_acc(3);
    chk("e_pc2", acc_pc[2], 32'h4);
    chk("e_ins2", acc_ins[2], 32'h0000_0013);

    // Reset asserted in the middle of an outstanding fetch.
    assert_reset();
    load_default();
    set_word(32'h0, 32'h0050_0093);
    mem_lat = 5;
    release_reset();
    for (int i = 0; i < 50 && !mem_valid; i++) tick();
    tick();
    #3;
    assert_reset();
    mem_lat = 0;
    release_reset();
    wait_acc(1);
    chk("f_fetch0", fetch_log[0], 32'h0);
    chk("f_pc0", acc_pc[0], 32'h0);
    chk("f_ins0", acc_ins[0], 32'h0050_0093);

    // pc wraps from the top halfword back to zero; redirect bit 0 ignored.
    assert_reset();
    load_default();
    set_word(32'hFFFF_FFFC, 32'h4501_0013);
    set_word(32'h0, 32'h0050_0093);
    mem_lat = 1;
    decoder_ready = 1'b0;
    release_reset();
    wait_fv();
    redirect(32'hFFFF_FFFF);
    decoder_ready = 1'b1;
    wait_acc(2);
    chk("g_pc0", acc_pc[0], 32'hFFFF_FFFE);
    chk("g_ins0", acc_ins[0], 32'h0000_4501);
    chk("g_pc1", acc_pc[1], 32'h0);
    chk("g_ins1", acc_ins[1], 32'h0050_0093);
    chk("g_fetch1", fetch_log[1], 32'hFFFF_FFFC);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first instruction address after reset (bit 0 ignored).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_valid  output  1  instruction-memory read request.
REQ-005 SHALL have port mem_ready  input  1  memory accepted request; mem_rdata valid this cycle.
REQ-006 SHALL have port mem_addr  output  32  word-aligned read address, bits [1:0] always 0.
REQ-007 SHALL have port mem_rdata  input  32  read data, little-endian halfwords.
REQ-008 SHALL have port fetcher_valid  output  1  instr/fetcher_pc hold an instruction for the decoder.
REQ-009 SHALL have port decoder_ready  input  1  decoder accepts instruction.
REQ-010 SHALL have port instr  output  32  instruction; compressed ones zero-extended in [31:16].
REQ-011 SHALL have port fetcher_pc  output  32  address of instr.
REQ-012 SHALL have port redirect_valid  input  1  single-cycle branch/jump/trap redirect.
REQ-013 SHALL have port redirect_pc  input  32  redirect target (bit 0 ignored).

Function
REQ-014 SHALL transfer an instruction only in a cycle with fetcher_valid && decoder_ready; instr, fetcher_pc stable while fetcher_valid && !decoder_ready.
REQ-015 SHALL keep internal pc (next fetch address) and 16-bit spill register with spill_valid holding upper halfword at address {pc[31:2],2'b10}.
REQ-016 SHALL use states IDLE (no request), FETCH (mem_valid high), FLUSH (request outstanding, data to discard).
REQ-017 SHALL start next instruction when output register is empty or being accepted this cycle.
REQ-018 SHALL, if pc[1]==1, spill_valid and spill[1:0]!=2'b11, output {16'h0,spill} next cycle without memory access, clear spill_valid, pc += 2.
REQ-019 SHALL otherwise enter FETCH with mem_addr = {pc[31:2],2'b00}, or pc+4's word when straddling (pc[1]==1, spill_valid, spill[1:0]==2'b11).
REQ-020 SHALL hold mem_valid and mem_addr constant from assertion until the mem_ready cycle; never drop a request early.
REQ-021 SHALL, on mem_ready with pc[1]==0: word[1:0]==11 -> instr=word, pc+=4; else instr={16'h0,word[15:0]}, spill=word[31:16], spill_valid=1, pc+=2.
REQ-022 SHALL, on mem_ready for straddle: instr={word[15:0],spill}, spill=word[31:16], spill_valid=1, pc+=4.
REQ-023 SHALL, on mem_ready with pc[1]==1 and no spill (post-redirect): spill=word[31:16], spill_valid=1, no output; then proceed per REQ-018/019.
REQ-024 SHALL register outputs: fetcher_valid rises the cycle after mem_ready (1-cycle latency); FETCH->IDLE on mem_ready.
REQ-025 SHALL, on redirect_valid: pc=redirect_pc&~1, spill_valid=0, fetcher_valid=0 next cycle; FETCH->FLUSH; FLUSH/IDLE restart fetch from new pc.
REQ-026 SHALL in FLUSH keep mem_valid until mem_ready, discard mem_rdata, then issue fetch at redirected pc.
REQ-027 SHALL give redirect_valid priority over simultaneous acceptance, mem_ready, or spill output; a redirect in FLUSH updates target only.
REQ-028 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFE + 2 = 0).

Reset
REQ-029 SHALL, while reset high (asynchronously): fetcher_valid=0, mem_valid=0, mem_addr=0, instr=0, fetcher_pc=0, spill_valid=0, spill=0, state=IDLE, pc=RESET_PC&~1.
REQ-030 SHALL abandon any outstanding memory request on reset mid-operation; first request issued on first clock edge after reset deasserts.

Structure
REQ-031 SHALL place the state enum (IDLE/FETCH/FLUSH) and halfword/word size constants in shared package cpu_pkg.
REQ-032 SHALL isolate halfword alignment (instr select, spill update, pc increment) in one combinational sub-module fetch_aligner.

Verification
REQ-033 SHALL cover: reset, mem_rdata 32'h0050_0093, ready 1 cycle -> instr 32'h0050_0093, fetcher_pc 0, next mem_addr 4.
REQ-034 SHALL cover: word 32'h4505_4501 at 0 -> instr 32'h0000_4501 pc 0, then 32'h0000_4505 pc 2, no second fetch of addr 0.
REQ-035 SHALL cover: word 32'h0093_4501 at 0, 32'h1234_0050 at 4 -> 32'h0000_4501 pc 0, 32'h0050_0093 pc 2 straddle.
REQ-036 SHALL cover: redirect to 32'h0000_0102 while FETCH at 0x40 -> data discarded, fetches 0x100, outputs halfword at pc 0x102.
REQ-037 SHALL cover: decoder_ready low 5 cycles -> instr/fetcher_pc stable, mem_valid stays 0 once output full and spill consumed.
REQ-038 SHALL cover: reset asserted mid-FETCH -> mem_valid 0 immediately, restart at RESET_PC.
